// File: rtl/branch_stack_pkg.sv
// rtl/branch_stack_pkg.sv - shared constants and types for the branch stack
package branch_stack_pkg;

  localparam int BSTACK_DEPTH = 4;
  localparam int BSTACK_CP_WIDTH = 64;

  typedef logic [BSTACK_DEPTH-1:0] B_MASK;
  typedef logic [31:0] ADDR;

  typedef enum logic [1:0] {
    BR_NOTHING = 2'd0,
    BR_CLEAR   = 2'd1,
    BR_SQUASH  = 2'd2
  } BR_TASK;

endpackage

// File: rtl/branch_stack_if.sv
// rtl/branch_stack_if.sv - dispatch/branch-FU facing signal bundle of the branch stack
interface branch_stack_if
  import branch_stack_pkg::*;
#(
  parameter int DEPTH    = BSTACK_DEPTH,
  parameter int CP_WIDTH = BSTACK_CP_WIDTH
) ();

  logic                alloc_en;
  logic [CP_WIDTH-1:0] alloc_cp;
  logic                resolve_valid;
  BR_TASK              resolve_task;
  logic [DEPTH-1:0]    resolve_b_id;
  ADDR                 resolve_target;

  logic [DEPTH-1:0]    alloc_b_id;
  logic [DEPTH-1:0]    alloc_b_mask;
  logic                full;
  logic [DEPTH-1:0]    clear_mask;
  logic                squash_valid;
  logic [DEPTH-1:0]    squash_mask;
  ADDR                 squash_target;
  logic [CP_WIDTH-1:0] squash_cp;
  logic                err;

  modport master (
    output alloc_en, alloc_cp, resolve_valid, resolve_task, resolve_b_id, resolve_target,
    input  alloc_b_id, alloc_b_mask, full, clear_mask, squash_valid, squash_mask,
           squash_target, squash_cp, err
  );

  modport slave (
    input  alloc_en, alloc_cp, resolve_valid, resolve_task, resolve_b_id, resolve_target,
    output alloc_b_id, alloc_b_mask, full, clear_mask, squash_valid, squash_mask,
           squash_target, squash_cp, err
  );

endinterface

// File: rtl/branch_stack_psel_lowest.sv
// rtl/branch_stack_psel_lowest.sv - one-hot grant of the lowest-index set request bit
module psel_lowest #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [WIDTH-1:0] gnt_o
);

  // Scan from the top down so the lowest set bit is the last (winning) assignment
  always_comb begin
    gnt_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (req_i[i]) begin
        gnt_o    = '0;
        gnt_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/branch_stack.sv
// rtl/branch_stack.sv - in-flight branch tracker with clear/squash broadcast; optional checks under BRANCH_STACK_CHECK_EN
module branch_stack
  import branch_stack_pkg::*;
#(
  parameter int DEPTH    = BSTACK_DEPTH,
  parameter int CP_WIDTH = BSTACK_CP_WIDTH
) (
  input logic           clock,
  input logic           reset,
  branch_stack_if.slave bus
);

  logic [DEPTH-1:0]    valid_q, valid_d;
  logic [DEPTH-1:0]    dep_q [DEPTH];
  logic [DEPTH-1:0]    dep_d [DEPTH];
  logic [CP_WIDTH-1:0] cp_q  [DEPTH];
  logic [CP_WIDTH-1:0] cp_d  [DEPTH];

  logic [DEPTH-1:0]    clear_mask_q, clear_mask_d;
  logic                squash_valid_q, squash_valid_d;
  logic [DEPTH-1:0]    squash_mask_q, squash_mask_d;
  ADDR                 squash_target_q, squash_target_d;
  logic [CP_WIDTH-1:0] squash_cp_q, squash_cp_d;

  logic [DEPTH-1:0]    grant;
  logic [DEPTH-1:0]    squash_set;
  logic [DEPTH-1:0]    resolved;
  logic [CP_WIDTH-1:0] sel_cp;
  logic                hit, do_clear, do_squash, do_alloc;

  psel_lowest #(.WIDTH(DEPTH)) u_free_sel (
    .req_i (~valid_q),
    .gnt_o (grant)
  );

  // Decode the resolution against live entries and build the squash set and checkpoint mux
  always_comb begin
    hit        = bus.resolve_valid && $onehot(bus.resolve_b_id) &&
                 |(bus.resolve_b_id & valid_q);
    do_clear   = hit && (bus.resolve_task == BR_CLEAR);
    do_squash  = hit && (bus.resolve_task == BR_SQUASH);
    squash_set = bus.resolve_b_id;
    sel_cp     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && |(dep_q[i] & bus.resolve_b_id)) squash_set[i] = 1'b1;
      if (bus.resolve_b_id[i]) sel_cp = sel_cp | cp_q[i];
    end
    resolved = do_clear ? bus.resolve_b_id : (do_squash ? squash_set : '0);
    do_alloc = bus.alloc_en && !(&valid_q) && !do_squash;
  end

  assign bus.alloc_b_id   = grant;
  assign bus.alloc_b_mask = valid_q & ~resolved;
  assign bus.full         = &valid_q;

  // Next entry state: retire resolved entries, strip a cleared bit, write the granted slot
  always_comb begin
    valid_d = valid_q & ~resolved;
    cp_d    = cp_q;
    for (int i = 0; i < DEPTH; i++) begin
      dep_d[i] = do_clear ? (dep_q[i] & ~bus.resolve_b_id) : dep_q[i];
      if (do_alloc && grant[i]) begin
        valid_d[i] = 1'b1;
        dep_d[i]   = valid_q & ~resolved;
        cp_d[i]    = bus.alloc_cp;
      end
    end
    clear_mask_d    = do_clear ? bus.resolve_b_id : '0;
    squash_valid_d  = do_squash;
    squash_mask_d   = do_squash ? squash_set : '0;
    squash_target_d = do_squash ? bus.resolve_target : '0;
    squash_cp_d     = do_squash ? sel_cp : '0;
  end

  // Entry storage and the one-cycle broadcast registers
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q         <= '0;
      clear_mask_q    <= '0;
      squash_valid_q  <= 1'b0;
      squash_mask_q   <= '0;
      squash_target_q <= '0;
      squash_cp_q     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        dep_q[i] <= '0;
        cp_q[i]  <= '0;
      end
    end else begin
      valid_q         <= valid_d;
      dep_q           <= dep_d;
      cp_q            <= cp_d;
      clear_mask_q    <= clear_mask_d;
      squash_valid_q  <= squash_valid_d;
      squash_mask_q   <= squash_mask_d;
      squash_target_q <= squash_target_d;
      squash_cp_q     <= squash_cp_d;
    end
  end

  assign bus.clear_mask    = clear_mask_q;
  assign bus.squash_valid  = squash_valid_q;
  assign bus.squash_mask   = squash_mask_q;
  assign bus.squash_target = squash_target_q;
  assign bus.squash_cp     = squash_cp_q;

`ifdef BRANCH_STACK_CHECK_EN
  logic err_q;
  logic proto_err;

  assign proto_err = (bus.alloc_en && (&valid_q)) ||
                     (bus.resolve_valid && (!$onehot(bus.resolve_b_id) || !hit ||
                                            (bus.resolve_task == BR_NOTHING)));

  // Sticky protocol-error flag, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) err_q <= 1'b0;
    else if (proto_err) err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule
